// File: rtl/assoc_cache.sv
// N-way set-associative write-back/write-allocate cache with LRU (POLICY=0) or FIFO (POLICY=1) victims.
// Define CACHE_PERF_CNT_EN to add the hit_cnt/miss_cnt performance counters.
module assoc_cache #(
    parameter int  LINE_ADDR_LEN = 3,
    parameter int  SET_ADDR_LEN  = 3,
    parameter int  TAG_ADDR_LEN  = 7,
    parameter int  WAY_CNT       = 4,
    parameter int  POLICY        = 0,
    localparam int MEM_ADDR_LEN  = TAG_ADDR_LEN + SET_ADDR_LEN,
    localparam int LINE_SIZE     = 1 << LINE_ADDR_LEN
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [31:0]             addr,
    input  logic                    rd_req,
    input  logic                    wr_req,
    input  logic [31:0]             wr_data,
    output logic [31:0]             rd_data,
    output logic                    miss,
    output logic                    mem_rd_req,
    output logic                    mem_wr_req,
    output logic [MEM_ADDR_LEN-1:0] mem_addr,
    output logic [32*LINE_SIZE-1:0] mem_wr_line,
    input  logic [32*LINE_SIZE-1:0] mem_rd_line,
    input  logic                    mem_gnt
`ifdef CACHE_PERF_CNT_EN
    ,
    output logic [31:0]             hit_cnt,
    output logic [31:0]             miss_cnt
`endif
);
    localparam int SET_SIZE = 1 << SET_ADDR_LEN;
    localparam int WAY_W    = $clog2(WAY_CNT);
    localparam int SET_LO   = 2 + LINE_ADDR_LEN;
    localparam int TAG_LO   = SET_LO + SET_ADDR_LEN;

    typedef enum logic [1:0] {IDLE, SWAP_OUT, SWAP_IN, SWAP_IN_OK} state_t;
    typedef logic [LINE_SIZE-1:0][31:0]             line_t;
    typedef logic [WAY_CNT-1:0][WAY_W-1:0]          ages_t;

    state_t                                state;
    line_t                                 data    [SET_SIZE][WAY_CNT];
    logic [WAY_CNT-1:0][TAG_ADDR_LEN-1:0]  tag_arr [SET_SIZE];
    logic [WAY_CNT-1:0]                    valid   [SET_SIZE];
    logic [WAY_CNT-1:0]                    dirty   [SET_SIZE];
    ages_t                                 ages    [SET_SIZE];
    logic [WAY_W-1:0]                      fifo_ptr[SET_SIZE];

    logic [LINE_ADDR_LEN-1:0] line_idx;
    logic [SET_ADDR_LEN-1:0]  set_idx, req_set;
    logic [TAG_ADDR_LEN-1:0]  tag_idx, req_tag;
    logic [WAY_W-1:0]         hit_way, vic_sel, vic_way;
    logic                     hit, req, vic_ptr, vic_ptr_r;
    logic [MEM_ADDR_LEN-1:0]  wb_addr;
    line_t                    fill_line;
    logic                     unused_addr;

    assign line_idx    = addr[2 +: LINE_ADDR_LEN];
    assign set_idx     = addr[SET_LO +: SET_ADDR_LEN];
    assign tag_idx     = addr[TAG_LO +: TAG_ADDR_LEN];
    assign unused_addr = ^{addr[31:TAG_LO+TAG_ADDR_LEN], addr[1:0]};

    assign req        = rd_req | wr_req;
    assign miss       = req && !(state == IDLE && hit);
    assign mem_rd_req = (state == SWAP_IN);
    assign mem_wr_req = (state == SWAP_OUT);

    always_comb begin
        mem_addr = '0;
        if (state == SWAP_OUT)     mem_addr = wb_addr;
        else if (state == SWAP_IN) mem_addr = {req_tag, req_set};
    end

    always_comb begin
        hit     = 1'b0;
        hit_way = '0;
        for (int w = 0; w < WAY_CNT; w++)
            if (valid[set_idx][w] && tag_arr[set_idx][w] == tag_idx) begin
                hit     = 1'b1;
                hit_way = WAY_W'(w);
            end
    end

    // Invalid ways always win; the policy only decides among a full set.
    always_comb begin
        logic found;
        found   = 1'b0;
        vic_sel = '0;
        vic_ptr = 1'b0;
        for (int w = WAY_CNT - 1; w >= 0; w--)
            if (!valid[set_idx][w]) begin
                vic_sel = WAY_W'(w);
                found   = 1'b1;
            end
        if (!found) begin
            if (POLICY == 0) begin
                for (int w = 0; w < WAY_CNT; w++)
                    if (ages[set_idx][w] == WAY_W'(WAY_CNT - 1)) vic_sel = WAY_W'(w);
            end else begin
                vic_sel = fifo_ptr[set_idx];
                vic_ptr = 1'b1;
            end
        end
    end

    function automatic ages_t touch(input ages_t a, input logic [WAY_W-1:0] k);
        touch = a;
        for (int w = 0; w < WAY_CNT; w++)
            if (a[w] < a[k]) touch[w] = a[w] + 1'b1;
        touch[k] = '0;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            rd_data     <= '0;
            mem_wr_line <= '0;
            fill_line   <= '0;
            wb_addr     <= '0;
            req_tag     <= '0;
            req_set     <= '0;
            vic_way     <= '0;
            vic_ptr_r   <= 1'b0;
            for (int s = 0; s < SET_SIZE; s++) begin
                valid[s]    <= '0;
                dirty[s]    <= '0;
                fifo_ptr[s] <= '0;
                for (int w = 0; w < WAY_CNT; w++) ages[s][w] <= WAY_W'(w);
            end
        end else begin
            case (state)
                IDLE: if (req) begin
                    if (hit) begin
                        ages[set_idx] <= touch(ages[set_idx], hit_way);
                        if (rd_req) rd_data <= data[set_idx][hit_way][line_idx];
                        else        dirty[set_idx][hit_way] <= 1'b1;
                    end else begin
                        vic_way   <= vic_sel;
                        vic_ptr_r <= vic_ptr;
                        req_tag   <= tag_idx;
                        req_set   <= set_idx;
                        if (valid[set_idx][vic_sel] && dirty[set_idx][vic_sel]) begin
                            mem_wr_line <= data[set_idx][vic_sel];
                            wb_addr     <= {tag_arr[set_idx][vic_sel], set_idx};
                            state       <= SWAP_OUT;
                        end else begin
                            state <= SWAP_IN;
                        end
                    end
                end
                SWAP_OUT: if (mem_gnt) state <= SWAP_IN;
                SWAP_IN: if (mem_gnt) begin
                    fill_line <= mem_rd_line;
                    state     <= SWAP_IN_OK;
                end
                SWAP_IN_OK: begin
                    valid[req_set][vic_way] <= 1'b1;
                    dirty[req_set][vic_way] <= 1'b0;
                    ages[req_set]           <= touch(ages[req_set], vic_way);
                    if (vic_ptr_r) fifo_ptr[req_set] <= fifo_ptr[req_set] + 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Line data and tags carry no reset; valid bits gate every use.
    always_ff @(posedge clk) begin
        if (state == IDLE && req && hit && !rd_req)
            data[set_idx][hit_way][line_idx] <= wr_data;
        if (state == SWAP_IN_OK) begin
            data[req_set][vic_way]    <= fill_line;
            tag_arr[req_set][vic_way] <= req_tag;
        end
    end

`ifdef CACHE_PERF_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hit_cnt  <= '0;
            miss_cnt <= '0;
        end else if (state == IDLE && req) begin
            if (hit) hit_cnt  <= hit_cnt + 1'b1;
            else     miss_cnt <= miss_cnt + 1'b1;
        end
    end
`else
    // counters compiled out: no hit_cnt/miss_cnt ports
`endif

endmodule
